// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Request-side controller for the 32-bit ALU. Accepts one operation request at
// a time, drives the ALU command and operand registers, samples the ALU result
// and flags, and returns one response per request. The compound operations
// MIN, MAX, EQ (one ALU pass) and ABSDIFF (two ALU passes) are sequenced here.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_op, req_a, req_b            opcode (0-11 legal) and operands
//   alu_command                     registered 3-bit ALU command code
//   alu_operandA, alu_operandB      registered ALU operands
//   alu_result, alu_zero,
//   alu_carryout, alu_overflow      combinational ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_zero,
//   rsp_carryout, rsp_overflow      final result and flags of the last pass
//   rsp_error                       set when the request carried an illegal opcode

module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_error
);

    localparam logic [3:0] OP_MIN     = 4'd8;
    localparam logic [3:0] OP_MAX     = 4'd9;
    localparam logic [3:0] OP_ABSDIFF = 4'd10;
    localparam logic [3:0] OP_EQ      = 4'd11;

    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_SLT = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        EXEC2,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [3:0]       op, op_n;
    logic [2:0]       cmd_n;
    logic [WIDTH-1:0] a_n, b_n;
    logic [WIDTH-1:0] result_n;
    logic             zero_n, carry_n, ovf_n, err_n;

    // Plain ops map straight onto the ALU code; the compare-based compounds
    // start with a signed SLT, and EQ is an XOR whose zero flag is the answer.
    function automatic logic [2:0] first_pass_cmd(input logic [3:0] code);
        if (!code[3])
            return code[2:0];
        else if (code == OP_EQ)
            return CMD_XOR;
        else
            return CMD_SLT;
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op           <= 4'd0;
            alu_command  <= 3'd0;
            alu_operandA <= '0;
            alu_operandB <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            state        <= state_n;
            op           <= op_n;
            alu_command  <= cmd_n;
            alu_operandA <= a_n;
            alu_operandB <= b_n;
            rsp_result   <= result_n;
            rsp_zero     <= zero_n;
            rsp_carryout <= carry_n;
            rsp_overflow <= ovf_n;
            rsp_error    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        op_n     = op;
        cmd_n    = alu_command;
        a_n      = alu_operandA;
        b_n      = alu_operandB;
        result_n = rsp_result;
        zero_n   = rsp_zero;
        carry_n  = rsp_carryout;
        ovf_n    = rsp_overflow;
        err_n    = rsp_error;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_op > OP_EQ) begin
                        // Illegal opcodes answer immediately and leave the ALU
                        // registers untouched.
                        err_n    = 1'b1;
                        result_n = '0;
                        zero_n   = 1'b0;
                        carry_n  = 1'b0;
                        ovf_n    = 1'b0;
                        state_n  = DONE;
                    end else begin
                        op_n    = req_op;
                        a_n     = req_a;
                        b_n     = req_b;
                        cmd_n   = first_pass_cmd(req_op);
                        err_n   = 1'b0;
                        state_n = EXEC;
                    end
                end
            end

            EXEC: begin
                zero_n  = alu_zero;
                carry_n = alu_carryout;
                ovf_n   = alu_overflow;
                state_n = DONE;
                unique case (op)
                    OP_MIN:  result_n = alu_result[0] ? alu_operandA : alu_operandB;
                    OP_MAX:  result_n = alu_result[0] ? alu_operandB : alu_operandA;
                    OP_EQ:   result_n = {{(WIDTH-1){1'b0}}, alu_zero};
                    OP_ABSDIFF: begin
                        // Order the operands so the second pass subtracts the
                        // smaller value from the larger one.
                        cmd_n = CMD_SUB;
                        if (alu_result[0]) begin
                            a_n = alu_operandB;
                            b_n = alu_operandA;
                        end
                        state_n = EXEC2;
                    end
                    default: result_n = alu_result;
                endcase
            end

            EXEC2: begin
                result_n = alu_result;
                zero_n   = alu_zero;
                carry_n  = alu_carryout;
                ovf_n    = alu_overflow;
                state_n  = DONE;
            end

            DONE: begin
                if (rsp_ready)
                    state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Testbench for alu_op_sequencer. Provides a behavioural 32-bit ALU behind the
// sequencer, applies a table of directed requests with hand-computed results,
// and runs hand-written sequences for ABSDIFF operand swapping, illegal
// opcodes, response back-pressure and reset during an operation.

module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carryout;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_carryout;
    logic        rsp_overflow;
    logic        rsp_error;

    int checks;
    int failures;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_command  (alu_command),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow),
        .rsp_error    (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD/SUB/SLT share an adder (SUB and SLT add ~B + 1) and
    // report its carry and signed overflow; logic ops report no carry/overflow.
    logic [32:0] alu_sum;
    logic [31:0] alu_bx;
    always_comb begin
        alu_bx       = (alu_command == 3'd0) ? alu_operandB : ~alu_operandB;
        alu_sum      = {1'b0, alu_operandA} + {1'b0, alu_bx} + {32'd0, (alu_command != 3'd0)};
        alu_result   = 32'd0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            3'd0, 3'd1: begin
                alu_result   = alu_sum[31:0];
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] == alu_bx[31]) && (alu_sum[31] != alu_operandA[31]);
            end
            3'd2: alu_result = alu_operandA ^ alu_operandB;
            3'd3: begin
                alu_carryout = alu_sum[32];
                alu_overflow = (alu_operandA[31] == alu_bx[31]) && (alu_sum[31] != alu_operandA[31]);
                alu_result   = {31'd0, alu_sum[31] ^ alu_overflow};
            end
            3'd4: alu_result = alu_operandA & alu_operandB;
            3'd5: alu_result = ~(alu_operandA & alu_operandB);
            3'd6: alu_result = ~(alu_operandA | alu_operandB);
            default: alu_result = alu_operandA | alu_operandB;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    int          lat;
    logic [2:0]  exec_cmd;
    logic        exec_ready;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [2:0]  last_cmd;

    // Compare one value against its expectation and keep the running counts.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Present a request at a falling edge and wait for the response. Latency is
    // counted in cycles from the cycle in which the request is accepted, and
    // the ALU command and req_ready seen one cycle after acceptance are returned.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic hold_ready, output int latency,
                                 output logic [2:0] cmd_seen, output logic ready_seen);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = hold_ready;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        latency    = 1;
        cmd_seen   = alu_command;
        ready_seen = req_ready;
        while (!rsp_valid && latency < 20) begin
            @(negedge clk);
            latency++;
        end
    endtask

    // Accept the pending response and confirm the sequencer is idle again.
    task automatic consume(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, "_ready_after"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;

        //            op     a             b             cmd   result        z     c     o     lat
        vecs.push_back('{4'd0,  32'd5,        32'd7,        3'd0, 32'd12,       1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd1,  32'd7,        32'd7,        3'd1, 32'd0,        1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd6,  32'd0,        32'd0,        3'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd8,  32'hFFFFFFFD, 32'd2,        3'd3, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd9,  32'hFFFFFFFD, 32'd2,        3'd3, 32'd2,        1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd10, 32'd3,        32'd10,       3'd3, 32'd7,        1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{4'd10, 32'd10,       32'd3,        3'd3, 32'd7,        1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{4'd10, 32'h80000000, 32'h7FFFFFFF, 3'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 3});
        vecs.push_back('{4'd11, 32'd1,        32'd2,        3'd2, 32'd0,        1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd4,  32'h000000F0, 32'h0000003C, 3'd4, 32'h00000030, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'd0,        1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd7,  32'h00000100, 32'h00000001, 3'd7, 32'h00000101, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd2,  32'hA5A5A5A5, 32'hFFFF0000, 3'd2, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd3,  32'd2,        32'hFFFFFFFF, 3'd3, 32'd0,        1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'd1,        3'd0, 32'd0,        1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'd1,        3'd0, 32'h80000000, 1'b0, 1'b0, 1'b1, 2});

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_alu_command", 32'(alu_command), 32'd0);
        checkOutput("rst_operandA", alu_operandA, 32'd0);
        checkOutput("rst_operandB", alu_operandB, 32'd0);
        checkOutput("rst_result", rsp_result, 32'd0);
        checkOutput("rst_flags", 32'({rsp_zero, rsp_carryout, rsp_overflow, rsp_error}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table of single requests; even entries hold rsp_ready high throughout.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, (i % 2 == 0), lat, exec_cmd, exec_ready);
            rsp_ready = 1'b0;
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("v%0d_exec_cmd", i), 32'(exec_cmd), 32'(vecs[i].cmd));
            checkOutput($sformatf("v%0d_busy", i), 32'(exec_ready), 32'd0);
            checkOutput($sformatf("v%0d_result", i), rsp_result, vecs[i].result);
            checkOutput($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].zero));
            checkOutput($sformatf("v%0d_carry", i), 32'(rsp_carryout), 32'(vecs[i].carry));
            checkOutput($sformatf("v%0d_overflow", i), 32'(rsp_overflow), 32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d_error", i), 32'(rsp_error), 32'd0);
            consume($sformatf("v%0d", i));
        end
        last_a   = vecs[vecs.size()-1].a;
        last_b   = vecs[vecs.size()-1].b;
        last_cmd = vecs[vecs.size()-1].cmd;

        // ABSDIFF 3,10: SLT pass then SUB pass with swapped operands.
        req_valid = 1'b1; req_op = 4'd10; req_a = 32'd3; req_b = 32'd10;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abs_swap_p1_cmd", 32'(alu_command), 32'd3);
        checkOutput("abs_swap_p1_A", alu_operandA, 32'd3);
        checkOutput("abs_swap_p1_B", alu_operandB, 32'd10);
        @(negedge clk);
        checkOutput("abs_swap_p2_cmd", 32'(alu_command), 32'd1);
        checkOutput("abs_swap_p2_A", alu_operandA, 32'd10);
        checkOutput("abs_swap_p2_B", alu_operandB, 32'd3);
        checkOutput("abs_swap_p2_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("abs_swap_valid", 32'(rsp_valid), 32'd1);
        checkOutput("abs_swap_result", rsp_result, 32'd7);
        consume("abs_swap");

        // ABSDIFF 10,3: operands keep their order on the SUB pass.
        req_valid = 1'b1; req_op = 4'd10; req_a = 32'd10; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abs_keep_p2_cmd", 32'(alu_command), 32'd1);
        checkOutput("abs_keep_p2_A", alu_operandA, 32'd10);
        checkOutput("abs_keep_p2_B", alu_operandB, 32'd3);
        @(negedge clk);
        checkOutput("abs_keep_result", rsp_result, 32'd7);
        consume("abs_keep");
        last_a = 32'd10; last_b = 32'd3; last_cmd = 3'd1;

        // Illegal opcode: one-cycle error response, ALU registers untouched.
        applyStimulus(4'd13, 32'hDEADBEEF, 32'h12345678, 1'b0, lat, exec_cmd, exec_ready);
        checkOutput("illegal_latency", 32'(lat), 32'd1);
        checkOutput("illegal_error", 32'(rsp_error), 32'd1);
        checkOutput("illegal_result", rsp_result, 32'd0);
        checkOutput("illegal_flags", 32'({rsp_zero, rsp_carryout, rsp_overflow}), 32'd0);
        checkOutput("illegal_cmd_held", 32'(alu_command), 32'(last_cmd));
        checkOutput("illegal_A_held", alu_operandA, last_a);
        checkOutput("illegal_B_held", alu_operandB, last_b);
        consume("illegal");

        // EQ with the consumer stalling for four cycles.
        applyStimulus(4'd11, 32'h55, 32'h55, 1'b0, lat, exec_cmd, exec_ready);
        checkOutput("eq_latency", 32'(lat), 32'd2);
        checkOutput("eq_cmd", 32'(exec_cmd), 32'd2);
        checkOutput("eq_result", rsp_result, 32'd1);
        checkOutput("eq_zero", 32'(rsp_zero), 32'd1);
        checkOutput("eq_error_cleared", 32'(rsp_error), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("eq_stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("eq_stall%0d_result", k), rsp_result, 32'd1);
            checkOutput($sformatf("eq_stall%0d_ready", k), 32'(req_ready), 32'd0);
        end
        consume("eq");

        // Reset while an ADD is in EXEC: immediate reset values, no response.
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd3; req_b = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("midrst_pre_A", alu_operandA, 32'd3);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_alu_command", 32'(alu_command), 32'd0);
        checkOutput("midrst_operandA", alu_operandA, 32'd0);
        checkOutput("midrst_operandB", alu_operandB, 32'd0);
        checkOutput("midrst_result", rsp_result, 32'd0);
        checkOutput("midrst_flags", 32'({rsp_zero, rsp_carryout, rsp_overflow, rsp_error}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst_quiet%0d", k), 32'(rsp_valid), 32'd0);
        end
        applyStimulus(4'd0, 32'd1, 32'd1, 1'b1, lat, exec_cmd, exec_ready);
        checkOutput("postrst_latency", 32'(lat), 32'd2);
        checkOutput("postrst_result", rsp_result, 32'd2);
        consume("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-side controller for the 32-bit ALU: accepts operation requests over a valid/ready handshake and drives the ALU's 3-bit command code and operand registers. It samples the ALU result and flags, and returns one response per request over a second valid/ready handshake. It also implements compound operations (MIN, MAX, ABSDIFF, EQ) by sequencing one or two ALU passes. It sits between the instruction/test front end and the ALU datapath.

## Interface
- WIDTH, 32, operand/result width in bits.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_op  in  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MIN, 9 MAX, 10 ABSDIFF, 11 EQ, 12-15 illegal.
- req_a, req_b  in  WIDTH  operands.
- alu_command  out  3  command code to the ALU, registered; values per the ALU command map (ADD 0 … OR 7).
- alu_operandA, alu_operandB  out  WIDTH  registered ALU operands.
- alu_result  in  WIDTH  ALU result, combinational from the alu_* outputs.
- alu_zero, alu_carryout, alu_overflow  in  1  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  final result.
- rsp_zero, rsp_carryout, rsp_overflow  out  1  ALU flags of the final pass.
- rsp_error  out  1  illegal opcode.

## Operation
- States: IDLE, EXEC, EXEC2, DONE.
- **IDLE**
  - req_ready=1.
  - On req_valid with a legal op: latch op, load alu_operandA=req_a and alu_operandB=req_b, load alu_command, go to EXEC.
  - alu_command loaded per op: direct code for ops 0-7; SLT(3) for MIN, MAX and ABSDIFF; XOR(2) for EQ.
  - On req_valid with an illegal op: rsp_error=1, rsp_result=0, all rsp flags 0, go to DONE; ALU registers are unchanged.
- **EXEC**: ALU inputs are sampled at the end of the cycle.
  - Ops 0-7: rsp_result=alu_result and flags captured.
  - MIN: rsp_result = alu_result[0] ? A : B.
  - MAX: rsp_result = alu_result[0] ? B : A.
  - EQ: rsp_result = {WIDTH-1 zeros, alu_zero}.
  - Flags for MIN, MAX and EQ are the raw flags of the SLT/XOR pass.
  - All ops except ABSDIFF go to DONE.
  - ABSDIFF: alu_command←SUB(1); if alu_result[0]=1, swap the operands (A←B, B←A); go to EXEC2.
- **EXEC2** (ABSDIFF only): capture alu_result and flags of the SUB pass, go to DONE.
- **DONE**
  - rsp_valid=1; all rsp_* outputs are held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - There is no same-cycle bypass to a new acceptance.
- SLT is signed two's-complement; the ALU returns the comparison in alu_result[0].
- ABSDIFF on the most-negative/most-positive pair wraps modulo 2^WIDTH; rsp_overflow reports it and no saturation is applied.
- alu_command and operands hold their values in IDLE and DONE; they change only on acceptance and on the EXEC→EXEC2 transition.
- rsp_error is cleared on the next legal acceptance.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0.
  - alu_command=0, alu_operandA/B=0.
  - rsp_result=0 and all rsp flags/error=0.
- Reset mid-operation drops the in-flight request; no response is produced for it.
- Request accepted at edge N:
  - Single-pass op: rsp_valid high from edge N+2.
  - ABSDIFF: rsp_valid high from edge N+3.
  - Illegal op: rsp_valid high from edge N+1.
- Response consumed at edge M (rsp_valid & rsp_ready): req_ready is high from edge M. Single-pass throughput is therefore 1 op per 3 cycles with rsp_ready held high.
- req_valid while not in IDLE is ignored; the requester must hold it.
- rsp_valid, once high, stays high with stable data until consumed.
- rsp_ready while rsp_valid=0 has no effect.

## Test plan
- ADD 5,7, rsp_ready=1: alu_command=0 in EXEC; rsp_result=12, zero=0, carryout=0, valid exactly 2 cycles after accept.
- SUB 7,7 then NOR 0,0, back to back: first gives result 0, zero=1, carryout=1; second gives 0xFFFFFFFF; req_ready low for exactly 3 cycles per op.
- MIN/MAX with a=0xFFFFFFFD (-3), b=2: MIN=0xFFFFFFFD, MAX=2; alu_command=3 during EXEC.
- ABSDIFF a=3, b=10: pass 1 SLT, pass 2 SUB with A=10, B=3; result 7, valid 3 cycles after accept. Repeat with a=10, b=3: no swap, result 7.
- Illegal op 13, then EQ 0x55,0x55 with rsp_ready held low 4 cycles:
  - Op 13: rsp_error=1, result 0, valid 1 cycle after accept; alu_* unchanged.
  - EQ: result 1, response held stable across the stall; rsp_error=0.
- Assert reset during EXEC of an ADD: all outputs go to their reset values immediately, no response follows, and the next ADD 1,1 returns 2.
